mem_port_arbiter: RTL and testbench

//   Shares the single synchronous memory port between two requesters:

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between two requesters.
// Port 0 is the CPU (fetch/ld/st), port 1 the secondary master (loader/DMA).
// Two-way round-robin arbitration with a single transaction in flight.
//
// Handshake: a requester raises reqN with wrN/addrN/wdataN stable and holds it
// until ackN pulses for one cycle; on the edge after ackN it either drops reqN
// or presents its next request. The arbiter latches the request fields at
// grant, so inputs are ignored for the rest of that transaction (a dropped req
// still completes and still gets its ack).
//
// Reads model a memory with RD_LAT cycles from mem_rd to valid mem_rdata.
module mem_port_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_ACK   = 3'd4
    } state_t;

    state_t        state;
    logic          prio;
    logic [2:0]    cnt;

    logic          gnt_any;
    logic          gnt_port;
    logic          gnt_wr;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_wdata;
    logic          lat_last;

    // Pick the winning port in IDLE: a lone requester wins, a tie goes to prio.
    always_comb begin
        gnt_any   = req0 | req1;
        gnt_port  = (req0 && req1) ? prio : req1;
        gnt_wr    = gnt_port ? wr1    : wr0;
        gnt_addr  = gnt_port ? addr1  : addr0;
        gnt_wdata = gnt_port ? wdata1 : wdata0;
        lat_last  = (cnt == 3'(RD_LAT - 1));
    end

    // Transaction FSM; strobes and acks are registered so each is high for
    // exactly the one state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            prio      <= 1'b0;
            cnt       <= 3'd0;
            owner     <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt_any) begin
                        owner     <= gnt_port;
                        mem_addr  <= gnt_addr;
                        mem_wdata <= gnt_wdata;
                        // Only a contested grant moves the round-robin pointer.
                        if (req0 && req1) begin
                            prio <= ~gnt_port;
                        end
                        if (gnt_wr) begin
                            state  <= S_WR;
                            mem_wr <= 1'b1;
                            ack0   <= ~gnt_port;
                            ack1   <= gnt_port;
                        end else begin
                            state  <= S_RD_ISSUE;
                            mem_rd <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    state <= S_IDLE;
                end
                S_RD_ISSUE: begin
                    state <= S_RD_WAIT;
                    cnt   <= 3'd0;
                end
                S_RD_WAIT: begin
                    if (lat_last) begin
                        if (owner) begin
                            rdata1 <= mem_rdata;
                        end else begin
                            rdata0 <= mem_rdata;
                        end
                        ack0  <= ~owner;
                        ack1  <= owner;
                        state <= S_RD_ACK;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_RD_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter, built with a 3-cycle read latency.
// A transaction-level reference (grant rules, spec latencies, reference memory)
// predicts every output each cycle; an ack-order scoreboard checks who completes.
module tb_mem_port_arbiter;

    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int RD_LAT = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, mem_rd, mem_wr, busy, owner;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [2:0]    dbg_state;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- memory behind the port ----------------
    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    logic [DW-1:0] rd_pipe [0:RD_LAT-1];
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Garbage flows through the read pipe except where a read was issued,
    // so a mistimed capture picks up the wrong value.
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] = mem_wdata;
        rd_pipe[0] <= mem_rd ? mem[mem_addr] : DW'($urandom);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // ---------------- reference model ----------------
    bit            m_active = 0, m_port = 0, m_wr = 0, m_prio = 0, m_owner = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    int            m_start = 0, m_end = 0;
    logic [0:0]    exp_q[$];
    logic [0:0]    ack_log[$];
    logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;

    // At each edge: if the port is free this cycle, grant per round-robin and
    // schedule the transaction's events from its grant cycle.
    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_prio = 0; m_owner = 0;
            m_addr = '0; m_wdata = '0;
            exp_q.delete();
        end else if ((!m_active || cyc > m_end) && (req0 || req1)) begin
            if (req0 && req1) begin
                m_port = m_prio;
                m_prio = !m_port;
            end else begin
                m_port = req1;
            end
            m_wr    = m_port ? wr1 : wr0;
            m_addr  = m_port ? addr1 : addr0;
            m_wdata = m_port ? wdata1 : wdata0;
            m_start = cyc;
            m_end   = m_wr ? cyc + 1 : cyc + 2 + RD_LAT;
            if (m_wr) ref_mem[m_addr] = m_wdata;
            else      m_rdata = ref_mem[m_addr];
            m_owner  = m_port;
            m_active = 1;
            exp_q.push_back(m_port);
        end
        cyc++;
    end

    // ---------------- per-cycle checker and scoreboard ----------------
    always @(negedge clk) begin
        logic e_wr, e_rd, e_ack, e_busy;
        logic [0:0] sb_port;
        if (reset) begin
            exp_rd0 = '0;
            exp_rd1 = '0;
            check_val("rst_ack0", ack0, 0);
            check_val("rst_ack1", ack1, 0);
            check_val("rst_mem_rd", mem_rd, 0);
            check_val("rst_mem_wr", mem_wr, 0);
            check_val("rst_busy", busy, 0);
            check_val("rst_owner", owner, 0);
            check_val("rst_rdata0", rdata0, 0);
            check_val("rst_rdata1", rdata1, 0);
            check_val("rst_mem_addr", mem_addr, 0);
            check_val("rst_mem_wdata", mem_wdata, 0);
            check_val("rst_state", dbg_state, 0);
        end else begin
            e_wr   = m_active && m_wr  && (cyc == m_start + 1);
            e_rd   = m_active && !m_wr && (cyc == m_start + 1);
            e_ack  = m_active && (cyc == m_end);
            e_busy = m_active && (cyc > m_start) && (cyc <= m_end);
            if (e_ack && !m_wr) begin
                if (m_port) exp_rd1 = m_rdata;
                else        exp_rd0 = m_rdata;
            end
            check_val("ack0", ack0, e_ack && !m_port);
            check_val("ack1", ack1, e_ack && m_port);
            check_val("mem_rd", mem_rd, e_rd);
            check_val("mem_wr", mem_wr, e_wr);
            check_val("busy", busy, e_busy);
            check_val("owner", owner, m_owner);
            check_val("mem_addr", mem_addr, m_addr);
            check_val("mem_wdata", mem_wdata, m_wdata);
            check_val("rdata0", rdata0, exp_rd0);
            check_val("rdata1", rdata1, exp_rd1);
            if (ack0 || ack1) begin
                ack_log.push_back(ack1);
                if (exp_q.size() == 0) begin
                    check_val("sb_spurious_ack", 1, 0);
                end else begin
                    sb_port = exp_q.pop_front();
                    check_val("sb_ack_port", ack1, sb_port);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int p, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req0 = r; wr0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; wr1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // mode 0: hold req until ack; 1: drop req right after the grant edge
    // (port known idle); 2: randomly drop/scramble inputs once granted.
    task automatic do_txn(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int mode);
        int n;
        bit got;
        @(posedge clk); #1;
        set_req(p, 1'b1, w, a, d);
        if (mode == 1) begin
            @(posedge clk); #1;
            set_req(p, 1'b0, 1'b1, AW'($urandom), DW'($urandom));
        end
        got = 0;
        n   = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if ((p == 0) ? ack0 : ack1) begin
                got = 1;
            end else if (mode == 2 && busy && owner == p[0] && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                set_req(p, 1'b0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            end
        end
        if (!got) check_val($sformatf("ack%0d_timeout", p), 0, 1);
    endtask

    task automatic release_port(input int p, input int n);
        @(posedge clk); #1;
        set_req(p, 1'b0, 1'b0, '0, '0);
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic random_port(input int p, input int n);
        int gap;
        for (int k = 0; k < n; k++) begin
            do_txn(p, 1'($urandom_range(0, 1)), 16'h0100 + AW'($urandom_range(0, 15)),
                   DW'($urandom), 2);
            gap = $urandom_range(0, 3);
            if (gap > 0) release_port(p, gap);
        end
        release_port(p, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i) * 16'h9E37 + 16'h1357;
            ref_mem[i] = 16'(i) * 16'h9E37 + 16'h1357;
        end
        mem[16'h0010]     = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Port 0 read of a known word.
        ack_log.delete();
        do_txn(0, 1'b0, 16'h0010, 16'h0000, 0);
        check_val("t1_rdata0", rdata0, 16'hBEEF);
        release_port(0, 1);
        check_val("t1_ack_count", ack_log.size(), 1);

        // Port 1 write, then port 0 reads it back.
        do_txn(1, 1'b1, 16'h0020, 16'h1234, 0);
        release_port(1, 1);
        do_txn(0, 1'b0, 16'h0020, 16'h5555, 0);
        check_val("t2_readback", rdata0, 16'h1234);
        release_port(0, 1);

        // Both ports held from reset: grants must alternate 0,1,0,1.
        pulse_reset();
        ack_log.delete();
        fork
            begin
                do_txn(0, 1'b0, 16'h0010, 16'h0000, 0);
                do_txn(0, 1'b1, 16'h0030, 16'hA0A0, 0);
                release_port(0, 1);
            end
            begin
                do_txn(1, 1'b1, 16'h0031, 16'hB1B1, 0);
                do_txn(1, 1'b0, 16'h0020, 16'h0000, 0);
                release_port(1, 1);
            end
        join
        @(posedge clk); #1;
        check_val("t3_ack_count", ack_log.size(), 4);
        for (int i = 0; i < ack_log.size(); i++)
            check_val($sformatf("t3_order%0d", i), ack_log[i], i % 2);
        check_val("t3_rdata1", rdata1, 16'h1234);

        // Reset while the read waits on memory: access is lost, next req0 wins.
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check_val("t5_busy", busy, 0);
        check_val("t5_mem_rd", mem_rd, 0);
        check_val("t5_rdata0", rdata0, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        ack_log.delete();
        do_txn(0, 1'b0, 16'h0030, 16'h0000, 0);
        check_val("t5_after_rdata0", rdata0, 16'hA0A0);
        release_port(0, 1);
        check_val("t5_ack_count", ack_log.size(), 1);

        // req0 dropped during RD_ISSUE still completes; pending req1 follows.
        ack_log.delete();
        fork
            do_txn(0, 1'b0, 16'h0010, 16'h0000, 1);
            begin
                release_port(1, 1);
                do_txn(1, 1'b0, 16'h0031, 16'h0000, 0);
                release_port(1, 1);
            end
        join
        @(posedge clk); #1;
        check_val("t6_ack_count", ack_log.size(), 2);
        for (int i = 0; i < ack_log.size(); i++)
            check_val($sformatf("t6_order%0d", i), ack_log[i], i % 2);
        check_val("t6_rdata0", rdata0, 16'hBEEF);
        check_val("t6_rdata1", rdata1, 16'hB1B1);

        // Random contention with drops and scrambled inputs after grant.
        fork
            random_port(0, 25);
            random_port(1, 25);
        join

        repeat (RD_LAT + 4) @(negedge clk);
        check_val("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound on the whole run.
    initial begin
        #200000;
        check_val("watchdog", 1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
